// File: rtl/ti_adc_pkg.sv
// Shared mode encodings, frame counter width and the saturating offset-correction
// helper used by the time-interleaved ADC capture path.
package ti_adc_pkg;

  typedef enum logic [1:0] {
    MODE_INTERLEAVED = 2'd0,
    MODE_SINGLE      = 2'd1
  } mode_e;

  localparam int FRAME_COUNT_W = 16;
  localparam int CORR_W        = 34;

  // Wider than BITS+OS_BITS+1 so the subtraction is exact for any width up to 32.
  function automatic logic [31:0] sat_correct(
    input logic [31:0] data,
    input logic [31:0] offset,
    input int          bits,
    input int          os_bits
  );
    logic signed [CORR_W-1:0] os_ext;
    logic signed [CORR_W-1:0] diff;
    logic signed [CORR_W-1:0] max_val;
    os_ext  = $signed({2'b00, offset} << (CORR_W - os_bits)) >>> (CORR_W - os_bits);
    diff    = $signed({2'b00, data}) - os_ext;
    max_val = $signed((CORR_W'(1) << bits) - CORR_W'(1));
    if (diff[CORR_W-1]) begin
      return '0;
    end else if (diff > max_val) begin
      return 32'(max_val);
    end
    return 32'(diff);
  endfunction

endpackage

// File: rtl/ti_adc_frame_fifo.sv
// First-word fall-through frame FIFO; accepts a push while full when a pop
// happens in the same cycle and holds the last popped frame when empty.
module ti_adc_frame_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             push_ok
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             full;
  logic             pop_ok;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CNT_FULL);
    push_ok = push && (!full || pop);
    pop_ok  = pop && !empty;

    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_q] = push_data;
    end
    wr_d   = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d   = pop_ok ? rd_q + 1'b1 : rd_q;
    last_d = pop_ok ? mem_q[rd_q] : last_q;

    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // Once drained the output keeps showing the frame that was last consumed.
    head_data = empty ? last_q : mem_q[rd_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ti_adc_frame_assembler.sv
// Capture stage behind the interleaved SAR core: strobe sequencing, offset
// correction, frame packing and FIFO hand-off with status flags.
module ti_adc_frame_assembler
  import ti_adc_pkg::*;
#(
  parameter int WAYS    = 8,
  parameter int BITS    = 9,
  parameter int OS_BITS = 8,
  parameter int DEPTH   = 4
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     EN,
  input  logic [1:0]               MODE,
  input  logic [$clog2(WAYS)-1:0]  SEL,
  input  logic [WAYS-1:0]          SLICE_VALID,
  input  logic [WAYS*BITS-1:0]     SLICE_DATA,
  input  logic [WAYS*OS_BITS-1:0]  OSCAL,
  input  logic                     CLR_ERR,
  output logic [WAYS*BITS-1:0]     FRAME_DATA,
  output logic                     FRAME_VALID,
  input  logic                     FRAME_READY,
  output logic                     CLKOUT_DES,
  output logic [FRAME_COUNT_W-1:0] FRAME_COUNT,
  output logic                     OVERFLOW,
  output logic                     SEQ_ERR
);
  localparam int PTR_W = $clog2(WAYS);
  localparam int FW    = WAYS * BITS;

  logic [PTR_W-1:0]         ptr_q, ptr_d;
  mode_e                    mode_prev_q, mode_prev_d;
  logic [PTR_W-1:0]         sel_prev_q, sel_prev_d;
  logic                     s1_valid_q, s1_valid_d;
  logic [PTR_W-1:0]         s1_lane_q, s1_lane_d;
  logic [BITS-1:0]          s1_data_q, s1_data_d;
  logic [FW-1:0]            lanes_q, lanes_d;
  logic                     done_q, done_d;
  logic                     clkout_q, clkout_d;
  logic [FRAME_COUNT_W-1:0] count_q, count_d;
  logic                     overflow_q, overflow_d;
  logic                     seq_err_q, seq_err_d;

  mode_e            mode_eff;
  logic             setting_chg;
  logic [PTR_W-1:0] base_ptr;
  logic [WAYS-1:0]  onehot_ptr;
  logic [WAYS-1:0]  slice0_only;
  logic             take;
  logic             seq_set;
  logic [PTR_W-1:0] take_slice;
  int               slice_idx;
  int               lane_idx;
  logic             fifo_empty;
  logic             push_ok;
  logic             pop;

  // A mode/slice change restarts the frame, and the current strobe is judged against lane 0.
  always_comb begin
    mode_eff    = (MODE == MODE_SINGLE) ? MODE_SINGLE : MODE_INTERLEAVED;
    setting_chg = (mode_eff != mode_prev_q) || (SEL != sel_prev_q);
    base_ptr    = setting_chg ? '0 : ptr_q;
    onehot_ptr  = '0;
    onehot_ptr[base_ptr] = 1'b1;
    slice0_only = {{(WAYS-1){1'b0}}, 1'b1};
    mode_prev_d = mode_eff;
    sel_prev_d  = SEL;

    take       = 1'b0;
    seq_set    = 1'b0;
    take_slice = base_ptr;
    s1_lane_d  = base_ptr;
    ptr_d      = base_ptr;

    if (!EN) begin
      ptr_d = '0;
    end else if (mode_eff == MODE_SINGLE) begin
      take_slice = SEL;
      if (SLICE_VALID[SEL]) begin
        take  = 1'b1;
        ptr_d = base_ptr + 1'b1;
      end
    end else if (SLICE_VALID == onehot_ptr) begin
      take  = 1'b1;
      ptr_d = base_ptr + 1'b1;
    end else if (SLICE_VALID != '0) begin
      seq_set = 1'b1;
      ptr_d   = '0;
      if (SLICE_VALID == slice0_only) begin
        take       = 1'b1;
        take_slice = '0;
        s1_lane_d  = '0;
        ptr_d      = PTR_W'(1);
      end
    end

    slice_idx  = int'(take_slice);
    s1_valid_d = take;
    s1_data_d  = BITS'(sat_correct(32'(SLICE_DATA[slice_idx*BITS +: BITS]),
                                   32'(OSCAL[slice_idx*OS_BITS +: OS_BITS]),
                                   BITS, OS_BITS));
  end

  // Registered sample lands in its lane; writing the last lane queues the frame for the FIFO.
  always_comb begin
    lane_idx = int'(s1_lane_q);
    lanes_d  = lanes_q;
    done_d   = 1'b0;
    if (s1_valid_q) begin
      lanes_d[lane_idx*BITS +: BITS] = s1_data_q;
      done_d = (s1_lane_q == PTR_W'(WAYS - 1));
    end

    pop        = !fifo_empty && FRAME_READY;
    clkout_d   = clkout_q ^ push_ok;
    count_d    = count_q + FRAME_COUNT_W'(push_ok);
    overflow_d = (done_q && !push_ok) ? 1'b1 : (CLR_ERR ? 1'b0 : overflow_q);
    seq_err_d  = seq_set ? 1'b1 : (CLR_ERR ? 1'b0 : seq_err_q);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      ptr_q       <= '0;
      mode_prev_q <= MODE_INTERLEAVED;
      sel_prev_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_lane_q   <= '0;
      s1_data_q   <= '0;
      lanes_q     <= '0;
      done_q      <= 1'b0;
      clkout_q    <= 1'b0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      mode_prev_q <= mode_prev_d;
      sel_prev_q  <= sel_prev_d;
      s1_valid_q  <= s1_valid_d;
      s1_lane_q   <= s1_lane_d;
      s1_data_q   <= s1_data_d;
      lanes_q     <= lanes_d;
      done_q      <= done_d;
      clkout_q    <= clkout_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      seq_err_q   <= seq_err_d;
    end
  end

  ti_adc_frame_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RSTN),
    .push      (done_q),
    .push_data (lanes_q),
    .pop       (pop),
    .head_data (FRAME_DATA),
    .empty     (fifo_empty),
    .push_ok   (push_ok)
  );

  assign FRAME_VALID = !fifo_empty;
  assign CLKOUT_DES  = clkout_q;
  assign FRAME_COUNT = count_q;
  assign OVERFLOW    = overflow_q;
  assign SEQ_ERR     = seq_err_q;

endmodule
